output_sr_chain: RTL and testbench
==================================

# output_sr_chain

Parametrised serial output shifter for driving external shift-register chains such as 74HC595-style latches and LED or segment drivers. Parallel words of DATA_W bits are serialised onto o_bit with a generated o_clk. A one-word holding register lets the next word be queued during a shift, and an o_latch strobe is emitted after each word. It sits between core logic and the output pins and replaces the fixed 8-bit, single-buffered output shifter.

## Interface

Parameters:
- DATA_W, default 8: word width in bits; must be at least 2.
- CLK_DIV, default 2: i_clk cycles per o_clk phase, low or high; must be at least 1.

Ports:
- i_clk  in  1  system clock; all state changes on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_load  in  1  load request, sampled on the i_clk rising edge.
- i_data  in  DATA_W  word to send; sampled when a load is accepted.
- i_lsb_first  in  1  bit order for the word; sampled together with i_data. 1 sends LSB first, 0 sends MSB first.
- o_bit  out  1  serial data.
- o_clk  out  1  serial clock; the receiver samples o_bit on its rising edge.
- o_latch  out  1  storage strobe, high for CLK_DIV cycles after the last bit of each word.
- o_busy  out  1  holding register full; a load is not accepted while this is high.
- o_active  out  1  shifter is in SHIFT or LATCH.
- o_overrun  out  1  sticky flag, set when i_load is asserted while o_busy is high. Cleared only by reset.

## Operation

- Reset (asynchronous, while i_rst_n is 0):
  - all outputs are 0;
  - the holding register is empty;
  - the state is IDLE.
- Accepting a load:
  - a load is accepted when i_load is 1 and o_busy is 0;
  - i_data and i_lsb_first go into the holding register, and o_busy is 1 from the next cycle;
  - i_load while o_busy is 1 drops the word and sets o_overrun; the holding register is unchanged.
- IDLE:
  - o_bit, o_clk and o_latch are 0;
  - if the holding register is full, the word moves into the shifter, the holding register is emptied (o_busy goes to 0), the bit counter is cleared and the state goes to SHIFT.
- SHIFT, per bit:
  - o_bit carries the current bit for 2*CLK_DIV cycles;
  - o_clk is 0 for the first CLK_DIV cycles and 1 for the last CLK_DIV cycles;
  - o_bit changes only where o_clk goes from 1 to 0, so data is stable for CLK_DIV cycles on both sides of the o_clk rising edge;
  - after bit DATA_W-1, the state goes to LATCH.
- LATCH:
  - o_clk is 0, o_bit is 0 and o_latch is 1 for CLK_DIV cycles;
  - on the last LATCH cycle, if the holding register is full, the word moves into the shifter directly (SHIFT, no IDLE cycle); otherwise the state goes to IDLE.
- Bit order is fixed per word by the latched copy of i_lsb_first; a change on the input during a shift has no effect on that word.
- The bit counter is $clog2(DATA_W) bits; the phase counter is $clog2(CLK_DIV)+1 bits.

## Timing

- Load accepted at edge N with the shifter in IDLE:
  - edge N+1: word moves to the shifter; o_busy drops, o_active rises, o_bit shows the first bit;
  - first o_clk rise at edge N+1+CLK_DIV.
- Word duration in o_active: 2*CLK_DIV*DATA_W + CLK_DIV cycles.
- Back-to-back:
  - a load accepted at any time during SHIFT or LATCH is sent with zero gap;
  - the first bit appears on the edge after o_latch falls.
- Load pattern "pulse i_load one cycle, then one idle cycle, then wait for !o_busy" never sets o_overrun.
- Reset mid-word: all outputs go to 0 at once, with no o_latch pulse; the queued word is lost.

## Test plan

- Reset: hold i_rst_n=0 for 4 cycles -> every output is 0; assert reset between clock edges -> outputs clear immediately.
- DATA_W=8, CLK_DIV=2, load 8'h01 with i_lsb_first=0:
  - o_bit at the 8 o_clk rising edges is 0,0,0,0,0,0,0,1;
  - o_active is high for exactly 34 cycles;
  - o_latch is high for 2 cycles.
- Same configuration, load 8'h01 with i_lsb_first=1 -> bits read 1,0,0,0,0,0,0,0; load 8'hAA with i_lsb_first=0 -> bits read 1,0,1,0,1,0,1,0.
- Back-to-back: load 8'hFF, then 8'h00 queued during the shift:
  - 16 o_clk pulses and 2 o_latch pulses;
  - o_active stays high for 68 contiguous cycles;
  - o_overrun stays 0.
- Overrun: two consecutive i_load cycles, 8'h12 then 8'h34, while the shifter is busy:
  - 8'h12 is accepted and 8'h34 is dropped;
  - o_overrun is 1 and stays 1 until reset;
  - only the current word and 8'h12 are sent.
- DATA_W=12, CLK_DIV=1, load 12'hA5C MSB-first:
  - 12 bits read 1010_0101_1100;
  - 25 active cycles;
  - drop i_rst_n at bit 5 -> all outputs 0 at once, no o_latch pulse.

Source files
------------

// File: rtl/output_sr_chain.sv
// Serial output shifter for 74HC595-style chains: one-word holding register,
// generated serial clock and a latch strobe after every word.
module output_sr_chain #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_lsb_first,
  output logic              o_bit,
  output logic              o_clk,
  output logic              o_latch,
  output logic              o_busy,
  output logic              o_active,
  output logic              o_overrun
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int PH_W  = $clog2(CLK_DIV) + 1;

  localparam logic [PH_W-1:0]  PH_BIT_LAST   = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_HALF       = PH_W'(CLK_DIV);
  localparam logic [PH_W-1:0]  PH_LATCH_LAST = PH_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic              order_lsb, order_lsb_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [PH_W-1:0]   phase, phase_nxt;
  logic [DATA_W-1:0] hold_data;
  logic              hold_lsb;
  logic              hold_full;
  logic              take;
  logic              accept;
  logic              bit_nxt, clk_nxt, latch_nxt;

  assign accept = i_load & ~hold_full;
  assign o_busy = hold_full;

  always_comb begin
    state_nxt     = state;
    shreg_nxt     = shreg;
    order_lsb_nxt = order_lsb;
    cnt_nxt       = cnt;
    phase_nxt     = phase;
    take          = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full) take = 1'b1;
      end
      SHIFT: begin
        if (phase == PH_BIT_LAST) begin
          phase_nxt = '0;
          if (cnt == CNT_LAST) begin
            state_nxt = LATCH;
          end else begin
            cnt_nxt   = cnt + 1'b1;
            shreg_nxt = order_lsb ? (shreg >> 1) : (shreg << 1);
          end
        end else begin
          phase_nxt = phase + 1'b1;
        end
      end
      LATCH: begin
        if (phase == PH_LATCH_LAST) begin
          phase_nxt = '0;
          if (hold_full) take = 1'b1;
          else           state_nxt = IDLE;
        end else begin
          phase_nxt = phase + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Handing the queued word to the shifter overrides the normal progression.
    if (take) begin
      state_nxt     = SHIFT;
      shreg_nxt     = hold_data;
      order_lsb_nxt = hold_lsb;
      cnt_nxt       = '0;
      phase_nxt     = '0;
    end
    // Pin outputs are decoded from next-state values so they leave a flop glitch-free.
    bit_nxt   = (state_nxt == SHIFT) &
                (order_lsb_nxt ? shreg_nxt[0] : shreg_nxt[DATA_W-1]);
    clk_nxt   = (state_nxt == SHIFT) & (phase_nxt >= PH_HALF);
    latch_nxt = (state_nxt == LATCH);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      order_lsb <= 1'b0;
      cnt       <= '0;
      phase     <= '0;
      o_bit     <= 1'b0;
      o_clk     <= 1'b0;
      o_latch   <= 1'b0;
      o_active  <= 1'b0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      order_lsb <= order_lsb_nxt;
      cnt       <= cnt_nxt;
      phase     <= phase_nxt;
      o_bit     <= bit_nxt;
      o_clk     <= clk_nxt;
      o_latch   <= latch_nxt;
      o_active  <= (state_nxt != IDLE);
    end
  end

  // take and accept are mutually exclusive: take needs a full holder, accept an empty one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_data <= '0;
      hold_lsb  <= 1'b0;
      hold_full <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      if (take) hold_full <= 1'b0;
      if (accept) begin
        hold_full <= 1'b1;
        hold_data <= i_data;
        hold_lsb  <= i_lsb_first;
      end
      if (i_load & hold_full) o_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_output_sr_chain.sv
// Bench for output_sr_chain: an 8-bit/div-2 and a 12-bit/div-1 instance checked
// every cycle against a word-timeline model, plus literal checks of captured bit streams.
module tb_output_sr_chain;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  load = '0;
  logic [1:0]  lsb = '0;
  logic [7:0]  data0 = '0;
  logic [11:0] data1 = '0;
  logic [1:0]  obit, oclk, olat, obusy, oact, oovr;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  output_sr_chain #(.DATA_W(8), .CLK_DIV(2)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load[0]), .i_data(data0),
    .i_lsb_first(lsb[0]), .o_bit(obit[0]), .o_clk(oclk[0]), .o_latch(olat[0]),
    .o_busy(obusy[0]), .o_active(oact[0]), .o_overrun(oovr[0])
  );

  output_sr_chain #(.DATA_W(12), .CLK_DIV(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load[1]), .i_data(data1),
    .i_lsb_first(lsb[1]), .o_bit(obit[1]), .o_clk(oclk[1]), .o_latch(olat[1]),
    .o_busy(obusy[1]), .o_active(oact[1]), .o_overrun(oovr[1])
  );

  function automatic int w_of(int i);
    return (i == 0) ? 8 : 12;
  endfunction

  function automatic int cd_of(int i);
    return (i == 0) ? 2 : 1;
  endfunction

  // Model: a word in flight is a cycle index t along its fixed timeline.
  bit          m_act[2];
  int          m_t[2];
  logic [15:0] m_word[2];
  bit          m_lsb[2];
  bit          m_hf[2];
  logic [15:0] m_hd[2];
  bit          m_hl[2];
  bit          m_ovr[2];

  task automatic model_step(int i, bit ld, logic [15:0] d, bit l);
    int total;
    bit tk;
    total = 2 * cd_of(i) * w_of(i) + cd_of(i);
    tk = 1'b0;
    if (m_act[i]) begin
      m_t[i]++;
      if (m_t[i] == total) begin
        if (m_hf[i]) tk = 1'b1;
        else         m_act[i] = 1'b0;
      end
    end else if (m_hf[i]) begin
      tk = 1'b1;
    end
    if (tk) begin
      m_act[i]  = 1'b1;
      m_t[i]    = 0;
      m_word[i] = m_hd[i];
      m_lsb[i]  = m_hl[i];
    end
    if (ld && m_hf[i]) m_ovr[i] = 1'b1;
    if (ld && !m_hf[i]) begin
      m_hf[i] = 1'b1;
      m_hd[i] = d;
      m_hl[i] = l;
    end else if (tk) begin
      m_hf[i] = 1'b0;
    end
  endtask

  function automatic logic [5:0] model_out(int i);
    logic b, c, lt;
    int per, bi, ph;
    b = 1'b0; c = 1'b0; lt = 1'b0;
    per = 2 * cd_of(i);
    if (m_act[i]) begin
      if (m_t[i] < per * w_of(i)) begin
        bi = m_t[i] / per;
        ph = m_t[i] % per;
        b  = m_word[i][m_lsb[i] ? bi : (w_of(i) - 1 - bi)];
        c  = (ph >= cd_of(i));
      end else begin
        lt = 1'b1;
      end
    end
    return {b, c, lt, m_hf[i], m_act[i], m_ovr[i]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] = 1'b0; m_t[i] = 0; m_hf[i] = 1'b0; m_ovr[i] = 1'b0;
        m_word[i] = '0; m_hd[i] = '0; m_lsb[i] = 1'b0; m_hl[i] = 1'b0;
      end
    end else begin
      model_step(0, load[0], {8'h00, data0}, lsb[0]);
      model_step(1, load[1], {4'h0, data1}, lsb[1]);
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [5:0] exp_v, act_v;
      exp_v = model_out(i);
      act_v = {obit[i], oclk[i], olat[i], obusy[i], oact[i], oovr[i]};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("[TB] FAIL cycle_compare inst%0d @%0t: bit/clk/latch/busy/active/ovr got %b expected %b",
                 i, $time, act_v, exp_v);
      end
    end
  end

  // Waveform monitor: bits captured at o_clk rises, plus activity and latch statistics.
  logic [31:0] cap[2];
  int nbits[2], act_cnt[2], lat_cnt[2], lat_pulses[2], run[2], max_run[2];
  logic [1:0] pclk = '0, plat = '0;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (oclk[i] && !pclk[i]) begin
        cap[i] = {cap[i][30:0], obit[i]};
        nbits[i]++;
      end
      if (olat[i]) lat_cnt[i]++;
      if (olat[i] && !plat[i]) lat_pulses[i]++;
      if (oact[i]) begin
        act_cnt[i]++;
        run[i]++;
        if (run[i] > max_run[i]) max_run[i] = run[i];
      end else begin
        run[i] = 0;
      end
    end
    pclk = oclk;
    plat = olat;
  end

  task automatic clear_mon(int i);
    cap[i] = '0; nbits[i] = 0; act_cnt[i] = 0; lat_cnt[i] = 0;
    lat_pulses[i] = 0; run[i] = 0; max_run[i] = 0;
  endtask

  task automatic check_output(string name, logic [31:0] act_v, logic [31:0] exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s: got 'h%0h expected 'h%0h", name, act_v, exp_v);
    end
  endtask

  task automatic apply_stimulus(int i, logic [15:0] d, bit l);
    @(negedge clk);
    load[i] = 1'b1;
    lsb[i]  = l;
    if (i == 0) data0 = d[7:0];
    else        data1 = d[11:0];
    @(negedge clk);
    load[i] = 1'b0;
  endtask

  task automatic wait_idle(int i, int budget);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!oact[i] && !obusy[i]) begin
        done = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!done) begin
      n_fail++;
      $display("[TB] FAIL idle_timeout inst%0d: still busy/active after %0d cycles, required idle", i, budget);
    end
  endtask

  task automatic run_word(int i, logic [15:0] d, bit l);
    clear_mon(i);
    apply_stimulus(i, d, l);
    wait_idle(i, 400);
  endtask

  initial begin
    $display("[TB] start");
    clear_mon(0);
    clear_mon(1);
    #1 rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check_output("reset_inst0", {oovr[0], oact[0], obusy[0], olat[0], oclk[0], obit[0]}, 0);
    check_output("reset_inst1", {oovr[1], oact[1], obusy[1], olat[1], oclk[1], obit[1]}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_word(0, 16'h01, 1'b0);
    check_output("msb01_bits", cap[0][7:0], 8'h01);
    check_output("msb01_nbits", nbits[0], 8);
    check_output("msb01_active_cycles", act_cnt[0], 34);
    check_output("msb01_latch_cycles", lat_cnt[0], 2);
    check_output("msb01_latch_pulses", lat_pulses[0], 1);

    run_word(0, 16'h01, 1'b1);
    check_output("lsb01_bits", cap[0][7:0], 8'h80);
    run_word(0, 16'hAA, 1'b0);
    check_output("msbAA_bits", cap[0][7:0], 8'hAA);

    clear_mon(0);
    apply_stimulus(0, 16'hFF, 1'b0);
    repeat (10) @(negedge clk);
    apply_stimulus(0, 16'h00, 1'b0);
    wait_idle(0, 400);
    check_output("b2b_bits", cap[0][15:0], 16'hFF00);
    check_output("b2b_clk_pulses", nbits[0], 16);
    check_output("b2b_latch_pulses", lat_pulses[0], 2);
    check_output("b2b_active_run", max_run[0], 68);
    check_output("b2b_overrun", oovr[0], 0);

    clear_mon(0);
    apply_stimulus(0, 16'h55, 1'b0);
    repeat (5) @(negedge clk);
    @(negedge clk);
    load[0] = 1'b1; data0 = 8'h12; lsb[0] = 1'b0;
    @(negedge clk);
    data0 = 8'h34;
    @(negedge clk);
    load[0] = 1'b0;
    wait_idle(0, 400);
    check_output("ovr_bits", cap[0][15:0], 16'h5512);
    check_output("ovr_nbits", nbits[0], 16);
    check_output("ovr_flag", oovr[0], 1);

    run_word(1, 16'hA5C, 1'b0);
    check_output("w12_bits", cap[1][11:0], 12'hA5C);
    check_output("w12_nbits", nbits[1], 12);
    check_output("w12_active_cycles", act_cnt[1], 25);
    check_output("ovr_sticky", oovr[0], 1);

    // Reset in the middle of bit 5 with a second word already queued.
    clear_mon(1);
    apply_stimulus(1, 16'hFFF, 1'b0);
    repeat (3) @(negedge clk);
    apply_stimulus(1, 16'h123, 1'b1);
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if (nbits[1] == 5) begin
          seen = 1'b1;
          break;
        end
      end
      check_output("w12_reach_bit5", seen, 1);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_reset_inst1", {oovr[1], oact[1], obusy[1], olat[1], oclk[1], obit[1]}, 0);
    check_output("async_reset_inst0", {oovr[0], oact[0], obusy[0], olat[0], oclk[0], obit[0]}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check_output("midword_no_latch", lat_pulses[1], 0);
    check_output("midword_queue_lost", nbits[1], 5);
    check_output("midword_idle", oact[1], 0);

    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      load[0] = ($urandom_range(0, 11) == 0);
      data0   = 8'($urandom);
      lsb[0]  = 1'($urandom);
      load[1] = ($urandom_range(0, 9) == 0);
      data1   = 12'($urandom);
      lsb[1]  = 1'($urandom);
      if (k == 1500) begin
        @(posedge clk);
        #3 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    @(negedge clk);
    load = '0;
    wait_idle(0, 500);
    wait_idle(1, 500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
